// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// trap cause codes and the opcode legality check.
package multicycle_control_unit_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_MUL = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04;
  localparam logic [5:0] OP_OR  = 6'h05;
  localparam logic [5:0] OP_CMP = 6'h06;
  localparam logic [5:0] OP_LUI = 6'h07;
  localparam logic [5:0] OP_LLI = 6'h08;
  localparam logic [5:0] OP_RSV = 6'h09;
  localparam logic [5:0] OP_JMP = 6'h0A;
  localparam logic [5:0] OP_JEQ = 6'h0B;
  localparam logic [5:0] OP_LOD = 6'h0C;
  localparam logic [5:0] OP_STR = 6'h0D;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Where an instruction goes after its EXEC cycle.
  typedef enum logic [1:0] {
    CLS_FETCH = 2'd0,
    CLS_WB    = 2'd1,
    CLS_MEM   = 2'd2
  } exec_next_t;

  // 0x09 is reserved and everything above STR is unassigned.
  function automatic logic op_defined(input logic [5:0] op);
    return (op <= OP_STR) && (op != OP_RSV);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_wait_timer.sv
// Memory wait-state counter: counts stalled MEM cycles and flags when the
// allowed number of wait cycles has been used up.
module cu_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(MAX_WAIT));

  // Count stalled cycles; saturate at MAX_WAIT so the flag stays asserted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: accepts instructions over a valid/ready handshake,
// sequences FETCH/DECODE/EXEC/MEM/WB and traps on illegal opcodes or memory
// timeouts. All control outputs are combinational from state and IR.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 26,
  parameter int FLAG_W   = 8,
  parameter int EQ_BIT   = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic [FLAG_W-1:0] status_reg,
  input  logic              mem_ready,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] alu_src1,
  output logic [REG_AW-1:0] alu_src2,
  output logic [REG_AW-1:0] alu_dest,
  output logic              reg_write_enable,
  output logic              imm,
  output logic [DATA_W-1:0] imm_val,
  output logic              load_pc,
  output logic [PC_W-1:0]   load_pc_val,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_data_in,
  output logic              busy,
  output logic              trap,
  output logic [1:0]        trap_cause
);

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [1:0]  cause_q, cause_nxt;
  logic        tmr_clear, tmr_en, tmr_expired;
  logic [5:0]  op;

  logic [3:0]        ex_alu;
  logic [REG_AW-1:0] ex_src1, ex_src2, ex_dest;
  logic              ex_imm;
  logic [DATA_W-1:0] ex_imm_val;
  logic              ex_load_pc;
  logic [PC_W-1:0]   ex_load_pc_val;
  exec_next_t        ex_next;

  // Status flags other than EQ, and IR bits beyond the jump target for small
  // PC_W, are legitimately ignored.
  logic unused_bits;
  assign unused_bits = ^{status_reg, ir};

  assign op = ir[31:26];

  // Instruction register fields are 5 bits wide; fit them to REG_AW.
  function automatic logic [REG_AW-1:0] reg_fld(input logic [4:0] f);
    return REG_AW'(f);
  endfunction

  cu_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  assign tmr_clear = (state != ST_MEM) || mem_ready;
  assign tmr_en    = (state == ST_MEM) && !mem_ready;

  // Decode the IR into the control bundle that EXEC drives and MEM/WB hold.
  always_comb begin
    ex_alu         = 4'd0;
    ex_src1        = '0;
    ex_src2        = '0;
    ex_dest        = '0;
    ex_imm         = 1'b0;
    ex_imm_val     = '0;
    ex_load_pc     = 1'b0;
    ex_load_pc_val = '0;
    ex_next        = CLS_FETCH;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
        ex_alu  = op[3:0];
        ex_src1 = reg_fld(ir[25:21]);
        ex_src2 = reg_fld(ir[20:16]);
        ex_dest = reg_fld(ir[15:11]);
        ex_next = CLS_WB;
      end
      OP_CMP: begin
        ex_alu  = OP_SUB[3:0];
        ex_src1 = reg_fld(ir[25:21]);
        ex_src2 = reg_fld(ir[20:16]);
      end
      OP_LUI: begin
        ex_dest    = reg_fld(ir[25:21]);
        ex_imm     = 1'b1;
        ex_imm_val = DATA_W'(ir[15:0]) << (DATA_W - 16);
        ex_next    = CLS_WB;
      end
      OP_LLI: begin
        ex_alu     = OP_OR[3:0];
        ex_src2    = reg_fld(ir[25:21]);
        ex_dest    = reg_fld(ir[25:21]);
        ex_imm     = 1'b1;
        ex_imm_val = DATA_W'(ir[15:0]);
        ex_next    = CLS_WB;
      end
      OP_JMP: begin
        ex_load_pc     = 1'b1;
        ex_load_pc_val = ir[PC_W-1:0];
      end
      OP_JEQ: begin
        ex_load_pc     = status_reg[EQ_BIT];
        ex_load_pc_val = ir[PC_W-1:0];
      end
      OP_LOD: begin
        ex_src1 = reg_fld(ir[20:16]);
        ex_dest = reg_fld(ir[25:21]);
        ex_next = CLS_MEM;
      end
      OP_STR: begin
        ex_src1 = reg_fld(ir[20:16]);
        ex_src2 = reg_fld(ir[25:21]);
        ex_next = CLS_MEM;
      end
      default: ;
    endcase
  end

  // Next-state and control outputs; everything is forced low during reset.
  always_comb begin
    state_nxt        = state;
    cause_nxt        = cause_q;
    instr_ready      = 1'b0;
    alu_op           = 4'd0;
    alu_src1         = '0;
    alu_src2         = '0;
    alu_dest         = '0;
    reg_write_enable = 1'b0;
    imm              = 1'b0;
    imm_val          = '0;
    load_pc          = 1'b0;
    load_pc_val      = '0;
    mem_rd           = 1'b0;
    mem_wr           = 1'b0;
    mem_data_in      = 1'b0;
    busy             = 1'b0;
    trap             = 1'b0;
    trap_cause       = CAUSE_NONE;
    if (!rst) begin
      trap_cause = cause_q;
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        alu_op   = ex_alu;
        alu_src1 = ex_src1;
        alu_src2 = ex_src2;
        alu_dest = ex_dest;
        imm      = ex_imm;
        imm_val  = ex_imm_val;
      end
      case (state)
        ST_FETCH: begin
          instr_ready = 1'b1;
          if (instr_valid) state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          busy = 1'b1;
          if (op == OP_NOP) begin
            state_nxt = ST_FETCH;
          end else if (op_defined(op)) begin
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        end
        ST_EXEC: begin
          busy        = 1'b1;
          load_pc     = ex_load_pc;
          load_pc_val = ex_load_pc_val;
          case (ex_next)
            CLS_WB:  state_nxt = ST_WB;
            CLS_MEM: state_nxt = ST_MEM;
            default: state_nxt = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          busy   = 1'b1;
          mem_rd = (op == OP_LOD);
          mem_wr = (op == OP_STR);
          if (mem_ready) begin
            state_nxt = (op == OP_LOD) ? ST_WB : ST_FETCH;
          end else if (tmr_expired) begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          busy             = 1'b1;
          reg_write_enable = 1'b1;
          mem_data_in      = (op == OP_LOD);
          state_nxt        = ST_FETCH;
        end
        ST_TRAP: begin
          busy = 1'b1;
          trap = 1'b1;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  // State, instruction register and sticky trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      ir      <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == ST_FETCH && instr_valid) ir <= instr;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected
// timelines built from the instruction semantics, compared every cycle.
module tb_multicycle_control_unit;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int PC_W     = 26;
  localparam int FLAG_W   = 8;
  localparam int EQ_BIT   = 0;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic [31:0]       instr = '0;
  logic              instr_ready;
  logic [FLAG_W-1:0] status_reg = '0;
  logic              mem_ready = 1'b0;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] alu_src1, alu_src2, alu_dest;
  logic              reg_write_enable, imm;
  logic [DATA_W-1:0] imm_val;
  logic              load_pc;
  logic [PC_W-1:0]   load_pc_val;
  logic              mem_rd, mem_wr, mem_data_in, busy, trap;
  logic [1:0]        trap_cause;

  multicycle_control_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W),
    .FLAG_W(FLAG_W), .EQ_BIT(EQ_BIT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .status_reg(status_reg), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_dest(alu_dest),
    .reg_write_enable(reg_write_enable), .imm(imm), .imm_val(imm_val),
    .load_pc(load_pc), .load_pc_val(load_pc_val), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .busy(busy), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  alu;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic        rwe;
    logic        imm;
    logic [31:0] iv;
    logic        lp;
    logic [25:0] lpv;
    logic        rd;
    logic        wr;
    logic        mdi;
    logic        busy;
    logic        trap;
    logic [1:0]  cause;
  } outs_t;

  typedef struct {
    logic       mr;
    logic [7:0] st;
    outs_t      e;
  } ent_t;

  ent_t  sched[$];
  outs_t hist[$];
  outs_t exp_cur = '0;
  bit    exp_en = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  function automatic outs_t dut_outs();
    return {instr_ready, alu_op, alu_src1, alu_src2, alu_dest, reg_write_enable, imm,
            imm_val, load_pc, load_pc_val, mem_rd, mem_wr, mem_data_in, busy, trap,
            trap_cause};
  endfunction

  function automatic outs_t idle_rec();
    outs_t r;
    r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Every cycle the driver has published an expectation for.
  always @(negedge clk) begin
    if (exp_en) begin
      outs_t act;
      act = dut_outs();
      vectors++;
      if (act !== exp_cur) begin
        miscompares++;
        $display("FAIL ctl cyc=%0d got=%h exp=%h", cyc, act, exp_cur);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic vld, input logic [31:0] ins, input logic mr,
                      input logic [7:0] st, input outs_t e);
    instr_valid = vld;
    instr       = ins;
    mem_ready   = mr;
    status_reg  = st;
    exp_cur     = e;
    exp_en      = 1;
    #3;
    hist.push_back(dut_outs());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(rb(), $urandom, rb(), 8'($urandom), '0);
    rst = 1'b0;
  endtask

  task automatic push(input logic mr, input logic [7:0] st, input outs_t e);
    ent_t en;
    en.mr = mr;
    en.st = st;
    en.e  = e;
    sched.push_back(en);
  endtask

  // Expected timeline after acceptance, straight from the instruction semantics.
  // w = MEM cycles without mem_ready before it arrives (> MAX_WAIT: never).
  task automatic build(input logic [31:0] ins, input int w, input logic [7:0] st);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rdf;
    logic [15:0] k;
    outs_t       b, ex, m, wb, t;
    int          cls;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rdf = ins[15:11]; k = ins[15:0];
    b = '0;
    b.busy = 1'b1;
    push(rb(), 8'($urandom), b);
    if (op == 6'h09 || op > 6'h0D) begin
      t = b; t.trap = 1'b1; t.cause = 2'b01;
      for (int i = 0; i < 5; i++) push(rb(), 8'($urandom), t);
      return;
    end
    if (op == 6'h00) return;
    ex = b;
    cls = 0;
    if (op >= 6'h01 && op <= 6'h05) begin
      ex.alu = op[3:0]; ex.s1 = rs; ex.s2 = rt; ex.d = rdf; cls = 1;
    end else if (op == 6'h06) begin
      ex.alu = 4'd2; ex.s1 = rs; ex.s2 = rt;
    end else if (op == 6'h07) begin
      ex.d = rs; ex.imm = 1'b1; ex.iv = {k, 16'h0000}; cls = 1;
    end else if (op == 6'h08) begin
      ex.alu = 4'd5; ex.s2 = rs; ex.d = rs; ex.imm = 1'b1; ex.iv = {16'h0000, k}; cls = 1;
    end else if (op == 6'h0A) begin
      ex.lp = 1'b1; ex.lpv = ins[25:0];
    end else if (op == 6'h0B) begin
      ex.lp = st[EQ_BIT]; ex.lpv = ins[25:0];
    end else if (op == 6'h0C) begin
      ex.s1 = rt; ex.d = rs; cls = 2;
    end else begin
      ex.s1 = rt; ex.s2 = rs; cls = 2;
    end
    push(rb(), st, ex);
    ex.lp = 1'b0; ex.lpv = '0;
    if (cls == 1) begin
      wb = ex; wb.rwe = 1'b1;
      push(rb(), 8'($urandom), wb);
    end else if (cls == 2) begin
      m = ex; m.rd = (op == 6'h0C); m.wr = (op == 6'h0D);
      if (w <= MAX_WAIT) begin
        for (int i = 0; i < w; i++) push(1'b0, 8'($urandom), m);
        push(1'b1, 8'($urandom), m);
        if (op == 6'h0C) begin
          wb = ex; wb.rwe = 1'b1; wb.mdi = 1'b1;
          push(rb(), 8'($urandom), wb);
        end
      end else begin
        for (int i = 0; i <= MAX_WAIT; i++) push(1'b0, 8'($urandom), m);
        t = b; t.trap = 1'b1; t.cause = 2'b10;
        for (int i = 0; i < 5; i++) push(rb(), 8'($urandom), t);
      end
    end
  endtask

  // hist[0] is the accept cycle; abort >= 0 asserts rst after that many cycles.
  task automatic issue(input logic [31:0] ins, input int w, input int gap,
                       input int abort, input logic [7:0] st);
    ent_t en;
    bit   trapped;
    int   n;
    for (int i = 0; i < gap; i++) step(1'b0, $urandom, rb(), 8'($urandom), idle_rec());
    hist.delete();
    step(1'b1, ins, rb(), 8'($urandom), idle_rec());
    sched.delete();
    build(ins, w, st);
    n = 0;
    trapped = 0;
    while (sched.size() > 0) begin
      if (abort >= 0 && n == abort) begin
        sched.delete();
        do_reset(3);
        return;
      end
      en = sched.pop_front();
      if (en.e.trap) trapped = 1;
      step(rb(), $urandom, en.mr, en.st, en.e);
      n++;
    end
    if (trapped) do_reset(3);
    else step(1'b0, $urandom, rb(), 8'($urandom), idle_rec());
  endtask

  function automatic int first_ready();
    for (int i = 1; i < hist.size(); i++) if (hist[i].rdy) return i;
    return -1;
  endfunction

  function automatic int count_rd();
    int c = 0;
    foreach (hist[i]) if (hist[i].rd) c++;
    return c;
  endfunction

  function automatic int count_wr();
    int c = 0;
    foreach (hist[i]) if (hist[i].wr) c++;
    return c;
  endfunction

  initial begin
    do_reset(3);
    hist.delete();
    step(1'b0, $urandom, 1'b0, 8'h00, idle_rec());
    chk("rst_ready", hist[0].rdy, 1);
    chk("rst_busy", hist[0].busy, 0);
    chk("rst_trap", {hist[0].trap, hist[0].cause}, 0);

    // ADD r1,r2 -> r3
    issue(32'h04221800, 0, 2, -1, 8'h00);
    chk("add_alu", hist[2].alu, 1);
    chk("add_srcs", {hist[2].s1, hist[2].s2, hist[2].d}, {5'd1, 5'd2, 5'd3});
    chk("add_wb_we", {hist[2].rwe, hist[3].rwe}, 2'b01);
    chk("add_latency", first_ready(), 4);

    // CMP then JEQ 0x123 taken, then not taken
    issue(32'h18220000, 0, 1, -1, 8'h00);
    chk("cmp_alu", hist[2].alu, 2);
    chk("cmp_latency", first_ready(), 3);
    issue(32'h2C000123, 0, 0, -1, 8'h01);
    chk("jeq_taken", {hist[2].lp, hist[3].lp}, 2'b10);
    chk("jeq_target", hist[2].lpv, 26'h123);
    chk("jeq_latency", first_ready(), 3);
    issue(32'h2C000123, 0, 0, -1, 8'hFE);
    chk("jeq_not_taken", hist[2].lp, 0);

    // LOD r4,[r5] with 3 wait states
    issue(32'h30850000, 3, 1, -1, 8'h00);
    chk("lod_rd_cycles", count_rd(), 4);
    chk("lod_wb", {hist[7].rwe, hist[7].mdi, hist[7].d}, {1'b1, 1'b1, 5'd4});
    chk("lod_latency", first_ready(), 8);

    // STR completing on the very last allowed wait cycle
    issue(32'h34A40000, MAX_WAIT, 0, -1, 8'h00);
    chk("str_maxwait_latency", first_ready(), 4 + MAX_WAIT);

    // STR that never gets mem_ready
    issue(32'h34A40000, MAX_WAIT + 1, 0, -1, 8'h00);
    chk("str_wr_cycles", count_wr(), MAX_WAIT + 1);
    chk("str_timeout", {hist[23].trap, hist[23].cause}, 3'b110);

    // Reserved opcode 0x09
    issue(32'h24000000, 0, 3, -1, 8'h00);
    chk("illegal_trap", {hist[2].rdy, hist[2].trap, hist[2].cause}, 4'b0101);

    // Reset in the middle of a stalled store
    issue(32'h34A40000, 10, 0, 4, 8'h00);
    hist.delete();
    step(1'b0, $urandom, 1'b0, 8'h00, idle_rec());
    chk("abort_fetch", {hist[0].rdy, hist[0].wr, hist[0].busy}, 3'b100);

    for (int n = 0; n < 300; n++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      int          w, ab;
      op = 6'($urandom_range(0, 14));
      if (op == 6'd14) op = 6'($urandom_range(14, 63));
      ins = {op, 26'($urandom)};
      w = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) w = MAX_WAIT + $urandom_range(0, 1);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      issue(ins, w, $urandom_range(0, 2), ab, 8'($urandom));
    end

    exp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
